block_pixel_writer: RTL and testbench
=====================================

// Module: block_pixel_writer
// PURPOSE
//  Downstream of the block drawer datapath. Takes its stream of block-local pixels
//  (x,y in 0..BLOCK_SIZE-1, signed 9-bit colour offset) for one board cell.
//  Maps each pixel to absolute screen coordinates and applies the offset to a
//  per-block base RGB colour, saturating per channel. Buffers results in a small
//  FIFO and presents them to the framebuffer write port with a valid/ready handshake.
// PARAMETERS
//  BLOCK_SIZE  20   pixel edge length of one cell
//  X_ORIGIN    220  screen x of board column 0
//  Y_ORIGIN    40   screen y of board row 0
//  COLS        10   board columns
//  ROWS        20   board rows
//  SCREEN_W    640  screen width; fb_x < SCREEN_W
//  SCREEN_H    480  screen height; fb_y < SCREEN_H
//  FIFO_DEPTH  4    output FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1   clock; only clock domain
//  reset       in   1   synchronous, active-high reset
//  cmd_valid   in   1   new block command offered
//  cmd_ready   out  1   high in IDLE only
//  cmd_col     in   4   board column of block
//  cmd_row     in   5   board row of block
//  cmd_rgb     in   24  base colour {R,G,B}, 8 bits each
//  in_valid    in   1   drawer pixel valid
//  in_ready    out  1   writer accepts pixel this cycle
//  in_x        in   10  block-local x
//  in_y        in   9   block-local y
//  in_color    in   9   signed colour offset, two's complement, -256..255
//  in_last     in   1   marks final pixel of the block
//  fb_valid    out  1   framebuffer write pending (FIFO not empty)
//  fb_ready    in   1   framebuffer accepts write
//  fb_x        out  10  absolute screen x
//  fb_y        out  9   absolute screen y
//  fb_rgb      out  24  saturated colour
//  done        out  1   one-cycle pulse: block fully written
//  err_oob     out  1   sticky: a pixel was dropped as out of range
// BEHAVIOUR
//  Reset values: state IDLE; FIFO and stage-1 register empty.
//   Outputs: cmd_ready=1, in_ready=0, fb_valid=0, fb_x=0, fb_y=0, fb_rgb=0, done=0, err_oob=0.
//   Reset mid-block discards all pending pixels and emits no done.
//  FSM: IDLE -> ACTIVE on cmd_valid&cmd_ready.
//   On that transition, latch col/row/rgb and clear err_oob.
//   ACTIVE -> DRAIN on accepted pixel with in_last=1.
//   DRAIN -> IDLE when stage 1 and FIFO are both empty; done=1 for that one cycle.
//  in_ready = (state==ACTIVE) && (fifo_count + s1_valid < FIFO_DEPTH). No overflow by construction.
//  Stage 1 (register, on accepted pixel):
//   sx = X_ORIGIN + col*BLOCK_SIZE + in_x; sy = Y_ORIGIN + row*BLOCK_SIZE + in_y.
//   Compute sx/sy 11 bits wide, then range-check.
//   Channel sums: base_ch + sign-extended in_color, in 10-bit signed.
//  Drop rule: in_x>=BLOCK_SIZE, in_y>=BLOCK_SIZE, col>=COLS, row>=ROWS,
//   sx>=SCREEN_W or sy>=SCREEN_H.
//   A dropped pixel is still handshaked but not written; err_oob<=1.
//   in_last on a dropped pixel still moves the FSM to DRAIN.
//  Stage 2 (FIFO write): clamp each channel sum to 0..255; push {sx,sy,rgb}.
//  Latency: pixel accepted at edge N, FIFO empty, fb_ready=1 -> fb_valid high after edge N+1.
//   Throughput 1 pixel/cycle.
//  FIFO: fb_* show the head entry; pop on fb_valid&fb_ready.
//   Simultaneous push and pop in the same cycle keeps the count unchanged.
//   Pointers wrap modulo FIFO_DEPTH. Order is preserved.
//  fb_x/fb_y/fb_rgb hold their last value when fb_valid=0.
//  cmd_valid outside IDLE is ignored. in_valid outside ACTIVE is ignored.
// TESTING
//  T1 cmd col0,row0,rgb 808080; pixel (0,0,+0x60).
//     -> fb (220,40,E0E0E0), fb_valid 2 cycles after accept.
//  T2 rgb F01008, offset +0x60 -> FF7068.
//     Offset -0x60 -> 900000. rgb FFFFFF, offset -0xFF -> 000000.
//  T3 fb_ready=0, drive 6 pixels -> exactly 4 accepted, in_ready=0.
//     Then fb_ready=1 -> 6 writes, in order.
//  T4 col9,row19, full 20x20 sweep, fb_ready=1 -> 400 writes, final (419,439).
//     done pulses once after the last pop; cmd_ready=1 next cycle.
//  T5 pixel in_x=20 -> no write, err_oob=1; next accepted cmd clears err_oob.
//  T6 reset with 3 entries in FIFO in ACTIVE -> next cycle fb_valid=0, cmd_ready=1.
//     No done pulse and no further writes.

Source files
------------

// File: rtl/block_pixel_writer.sv
// block_pixel_writer: maps block-local drawer pixels to screen
// coordinates, applies a saturating colour offset to the block's
// base RGB, and queues the results for the framebuffer write port.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           block command handshake
//   cmd_col/cmd_row/cmd_rgb       board cell and base colour {R,G,B}
//   in_valid/in_ready             drawer pixel handshake
//   in_x/in_y/in_color/in_last    local pixel, signed offset, last flag
//   fb_valid/fb_ready             framebuffer write handshake
//   fb_x/fb_y/fb_rgb              head-of-queue write (held when empty)
//   done                          one-cycle pulse when block is written
//   err_oob                       sticky flag for dropped pixels
module block_pixel_writer #(
  parameter int BLOCK_SIZE = 20,
  parameter int X_ORIGIN   = 220,
  parameter int Y_ORIGIN   = 40,
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_col,
  input  logic [4:0]  cmd_row,
  input  logic [23:0] cmd_rgb,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_x,
  input  logic [8:0]  in_y,
  input  logic [8:0]  in_color,
  input  logic        in_last,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic [9:0]  fb_x,
  output logic [8:0]  fb_y,
  output logic [23:0] fb_rgb,
  output logic        done,
  output logic        err_oob
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [10:0]   LP_BS   = 11'(BLOCK_SIZE);
  localparam logic [10:0]   LP_XO   = 11'(X_ORIGIN);
  localparam logic [10:0]   LP_YO   = 11'(Y_ORIGIN);
  localparam logic [10:0]   LP_SW   = 11'(SCREEN_W);
  localparam logic [10:0]   LP_SH   = 11'(SCREEN_H);
  localparam logic [4:0]    LP_COLS = 5'(COLS);
  localparam logic [5:0]    LP_ROWS = 6'(ROWS);
  localparam logic [CW-1:0] LP_DEP  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LP_CONE = CW'(1);
  localparam logic [AW-1:0] LP_PONE = AW'(1);

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [23:0] rgb;
  } pix_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [3:0]  r_col;
  logic [4:0]  r_row;
  logic [23:0] r_rgb;
  logic        r_err;

  logic        r_s1_valid;
  logic [9:0]  r_s1_x;
  logic [8:0]  r_s1_y;
  logic [9:0]  r_s1_r;
  logic [9:0]  r_s1_g;
  logic [9:0]  r_s1_b;

  pix_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  pix_t          r_hold;

  logic          w_cmd_fire;
  logic          w_in_fire;
  logic          w_drop;
  logic [10:0]   w_sx;
  logic [10:0]   w_sy;
  logic [9:0]    w_off;
  logic [CW-1:0] w_occ;
  logic          w_empty_all;
  logic          w_push;
  logic          w_pop;
  pix_t          w_push_data;
  pix_t          w_out;

  function automatic logic [7:0] f_clamp(input logic [9:0] s);
    if (s[9]) begin
      return 8'h00;
    end else if (s[8]) begin
      return 8'hFF;
    end else begin
      return s[7:0];
    end
  endfunction

  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_in_fire   = in_valid && in_ready;
  assign w_occ       = r_count + CW'(r_s1_valid);
  assign w_empty_all = !r_s1_valid && (r_count == '0);
  assign w_push      = r_s1_valid;
  assign w_pop       = (r_count != '0) && fb_ready;

  // 11 bits hold the worst case (col/row/local at their field maxima)
  assign w_sx = LP_XO + 11'(r_col) * LP_BS + {1'b0, in_x};
  assign w_sy = LP_YO + 11'(r_row) * LP_BS + {2'b0, in_y};
  assign w_off = {in_color[8], in_color};

  assign w_drop = ({1'b0, in_x} >= LP_BS)
               || ({2'b0, in_y} >= LP_BS)
               || ({1'b0, r_col} >= LP_COLS)
               || ({1'b0, r_row} >= LP_ROWS)
               || (w_sx >= LP_SW)
               || (w_sy >= LP_SH);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) w_state_nx = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_in_fire && in_last) w_state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_empty_all) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE:   cmd_ready = 1'b1;
      S_ACTIVE: in_ready  = (w_occ < LP_DEP);
      S_DRAIN:  done      = w_empty_all;
      default:  cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
      r_rgb <= '0;
      r_err <= 1'b0;
    end else if (w_cmd_fire) begin
      r_col <= cmd_col;
      r_row <= cmd_row;
      r_rgb <= cmd_rgb;
      r_err <= 1'b0;
    end else if (w_in_fire && w_drop) begin
      r_err <= 1'b1;
    end
  end

  assign err_oob = r_err;

  // Stage 1: dropped pixels complete the handshake but never
  // occupy the stage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
    end else begin
      r_s1_valid <= w_in_fire && !w_drop;
      if (w_in_fire) begin
        r_s1_x <= w_sx[9:0];
        r_s1_y <= w_sy[8:0];
        r_s1_r <= {2'b00, r_rgb[23:16]} + w_off;
        r_s1_g <= {2'b00, r_rgb[15:8]} + w_off;
        r_s1_b <= {2'b00, r_rgb[7:0]} + w_off;
      end
    end
  end

  // Stage 2: saturate and push
  always_comb begin
    w_push_data.x   = r_s1_x;
    w_push_data.y   = r_s1_y;
    w_push_data.rgb = {f_clamp(r_s1_r),
                       f_clamp(r_s1_g),
                       f_clamp(r_s1_b)};
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  // r_hold keeps the last popped entry so fb_* stay put when empty
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + LP_PONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + LP_PONE;
        r_hold <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CONE;
        2'b01:   r_count <= r_count - LP_CONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign fb_valid = (r_count != '0);
  assign w_out    = fb_valid ? r_mem[r_rptr] : r_hold;
  assign fb_x     = w_out.x;
  assign fb_y     = w_out.y;
  assign fb_rgb   = w_out.rgb;

endmodule

// File: tb/tb_block_pixel_writer.sv
// Testbench for block_pixel_writer: directed scenarios plus a
// randomized run checked against an arithmetic reference model.
module tb_block_pixel_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_col;
  logic [4:0]  cmd_row;
  logic [23:0] cmd_rgb;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_x;
  logic [8:0]  in_y;
  logic [8:0]  in_color;
  logic        in_last;
  logic        fb_valid;
  logic        fb_ready;
  logic [9:0]  fb_x;
  logic [8:0]  fb_y;
  logic [23:0] fb_rgb;
  logic        done;
  logic        err_oob;

  block_pixel_writer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_rgb(cmd_rgb),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_color(in_color),
    .in_last(in_last),
    .fb_valid(fb_valid), .fb_ready(fb_ready),
    .fb_x(fb_x), .fb_y(fb_y), .fb_rgb(fb_rgb),
    .done(done), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int cyc = 0;
  bit rnd_fb = 0;

  logic [42:0] exp_q[$];
  logic [42:0] got_q[$];

  int          m_col;
  int          m_row;
  logic [23:0] m_rgb;
  bit          m_err;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset && fb_valid && fb_ready)
      got_q.push_back({fb_x, fb_y, fb_rgb});
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_fb) fb_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [42:0] model_pix(
    input int x, input int y, input logic [8:0] c,
    output bit drop);
    int sx, sy, off;
    int ch[3];
    sx = 220 + m_col * 20 + x;
    sy = 40 + m_row * 20 + y;
    drop = (x >= 20) || (y >= 20) || (m_col >= 10)
        || (m_row >= 20) || (sx >= 640) || (sy >= 480);
    off = (c >= 256) ? int'(c) - 512 : int'(c);
    for (int i = 0; i < 3; i++) begin
      ch[i] = int'(m_rgb[23-8*i -: 8]) + off;
      if (ch[i] < 0) ch[i] = 0;
      if (ch[i] > 255) ch[i] = 255;
    end
    return {10'(sx), 9'(sy), 8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
  endfunction

  task automatic send_cmd(input int col, input int row,
                          input logic [23:0] rgb);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_col = 4'(col);
    cmd_row = 5'(row);
    cmd_rgb = rgb;
    while (!cmd_ready && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_timeout cmd_ready=%b required=1", cmd_ready);
    end else begin
      m_col = col;
      m_row = row;
      m_rgb = rgb;
      m_err = 0;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_pix(input int x, input int y,
                          input logic [8:0] c, input bit last);
    int n = 0;
    bit drop;
    logic [42:0] e;
    in_valid = 1'b1;
    in_x = 10'(x);
    in_y = 9'(y);
    in_color = c;
    in_last = last;
    while (!in_ready && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL pix_timeout in_ready=%b required=1", in_ready);
    end else begin
      e = model_pix(x, y, c, drop);
      if (drop) m_err = 1;
      else exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit saw);
    saw = 0;
    for (int n = 0; n < 3000; n++) begin
      if (done === 1'b1) begin
        saw = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({cmd_ready, in_ready, fb_valid, done, err_oob} !== 5'b10000) begin
      failures++;
      $display("FAIL rst_ctl got=%b required=10000",
               {cmd_ready, in_ready, fb_valid, done, err_oob});
    end
    checks++;
    if ({fb_x, fb_y, fb_rgb} !== 43'd0) begin
      failures++;
      $display("FAIL rst_data got=%h required=0", {fb_x, fb_y, fb_rgb});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    got_q.delete();
    exp_q.delete();
    send_cmd(0, 0, 24'h808080);
    in_valid = 1'b1;
    in_x = 10'd0;
    in_y = 9'd0;
    in_color = 9'h060;
    in_last = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL t1_ready got=%b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (fb_valid !== 1'b0) begin
      failures++;
      $display("FAIL t1_early got=%b required=0", fb_valid);
    end
    tick();
    checks++;
    if ({fb_valid, fb_x, fb_y, fb_rgb}
        !== {1'b1, 10'd220, 9'd40, 24'hE0E0E0}) begin
      failures++;
      $display("FAIL t1_out got=%b %0d %0d %h required=1 220 40 e0e0e0",
               fb_valid, fb_x, fb_y, fb_rgb);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL t1_done got=%b required=1", done);
    end
    checks++;
    if ({fb_valid, fb_x, fb_y, fb_rgb}
        !== {1'b0, 10'd220, 9'd40, 24'hE0E0E0}) begin
      failures++;
      $display("FAIL t1_hold got=%b %0d %0d %h required=0 220 40 e0e0e0",
               fb_valid, fb_x, fb_y, fb_rgb);
    end
    tick();
    checks++;
    if ({cmd_ready, done} !== 2'b10) begin
      failures++;
      $display("FAIL t1_idle got=%b required=10", {cmd_ready, done});
    end
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL t1_writes got=%0d required=1", got_q.size());
    end
  endtask

  task automatic test_saturation();
    bit saw;
    logic [23:0] req[3];
    req[0] = 24'hFF7068;
    req[1] = 24'h900000;
    req[2] = 24'h000000;
    got_q.delete();
    exp_q.delete();
    send_cmd(3, 5, 24'hF01008);
    send_pix(1, 2, 9'h060, 0);
    send_pix(4, 7, 9'h1A0, 1);
    wait_done(saw);
    tick();
    send_cmd(0, 19, 24'hFFFFFF);
    send_pix(19, 19, 9'h101, 1);
    wait_done(saw);
    tick();
    checks++;
    if (got_q.size() != 3) begin
      failures++;
      $display("FAIL t2_count got=%0d required=3", got_q.size());
    end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i][23:0] !== req[i]) begin
        failures++;
        $display("FAIL t2_rgb[%0d] got=%h required=%h",
                 i, got_q[i][23:0], req[i]);
      end
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t2_pix[%0d] got=%h required=%h",
                 i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int px[6], py[6];
    logic [8:0] pc[6];
    int acc = 0;
    bit drop, saw;
    got_q.delete();
    exp_q.delete();
    send_cmd($urandom_range(0, 9), $urandom_range(0, 19), 24'($urandom));
    for (int i = 0; i < 6; i++) begin
      px[i] = $urandom_range(0, 19);
      py[i] = $urandom_range(0, 19);
      pc[i] = 9'($urandom);
    end
    fb_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_x = 10'(px[acc]);
      in_y = 9'(py[acc]);
      in_color = pc[acc];
      in_last = (acc == 5);
      if (in_ready) begin
        exp_q.push_back(model_pix(px[acc], py[acc], pc[acc], drop));
        acc++;
      end
      tick();
    end
    checks++;
    if (acc != 4) begin
      failures++;
      $display("FAIL t3_accepted got=%0d required=4", acc);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL t3_stall got=%b required=0", in_ready);
    end
    checks++;
    if ({fb_valid, fb_x, fb_y, fb_rgb} !== {1'b1, exp_q[0]}) begin
      failures++;
      $display("FAIL t3_head got=%b %h required=1 %h",
               fb_valid, {fb_x, fb_y, fb_rgb}, exp_q[0]);
    end
    fb_ready = 1'b1;
    while (acc < 6) begin
      send_pix(px[acc], py[acc], pc[acc], acc == 5);
      acc++;
    end
    wait_done(saw);
    checks++;
    if (!saw) begin
      failures++;
      $display("FAIL t3_done got=0 required=1");
    end
    tick();
    checks++;
    if (got_q.size() != 6) begin
      failures++;
      $display("FAIL t3_count got=%0d required=6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t3_pix[%0d] got=%h required=%h",
                 i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_sweep();
    int c0, d0;
    bit saw;
    got_q.delete();
    exp_q.delete();
    fb_ready = 1'b1;
    send_cmd(9, 19, 24'($urandom));
    c0 = cyc;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 20; x++)
        send_pix(x, y, 9'($urandom), (x == 19) && (y == 19));
    checks++;
    if (cyc - c0 != 400) begin
      failures++;
      $display("FAIL t4_rate got=%0d required=400", cyc - c0);
    end
    d0 = done_cnt;
    wait_done(saw);
    tick();
    checks++;
    if ({saw, cmd_ready, done} !== 3'b110) begin
      failures++;
      $display("FAIL t4_end got=%b required=110", {saw, cmd_ready, done});
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL t4_pulses got=%0d required=1", done_cnt - d0);
    end
    checks++;
    if (got_q.size() != 400) begin
      failures++;
      $display("FAIL t4_count got=%0d required=400", got_q.size());
    end else begin
      checks++;
      if (got_q[399][42:24] !== {10'd419, 9'd439}) begin
        failures++;
        $display("FAIL t4_final got=%0d,%0d required=419,439",
                 got_q[399][42:33], got_q[399][32:24]);
      end
    end
    for (int i = 0; i < 400 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL t4_pix[%0d] got=%h required=%h",
                 i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_oob();
    bit saw;
    got_q.delete();
    exp_q.delete();
    send_cmd(2, 3, 24'($urandom));
    send_pix(20, 5, 9'($urandom), 0);
    checks++;
    if (err_oob !== 1'b1) begin
      failures++;
      $display("FAIL t5_err_set got=%b required=1", err_oob);
    end
    send_pix(4, 25, 9'($urandom), 1);
    wait_done(saw);
    checks++;
    if (!saw) begin
      failures++;
      $display("FAIL t5_drain got=0 required=1");
    end
    tick();
    checks++;
    if ({got_q.size() == 0, err_oob} !== 2'b11) begin
      failures++;
      $display("FAIL t5_drop writes=%0d err=%b required=0 1",
               got_q.size(), err_oob);
    end
    send_cmd(1, 1, 24'($urandom));
    checks++;
    if (err_oob !== 1'b0) begin
      failures++;
      $display("FAIL t5_err_clr got=%b required=0", err_oob);
    end
    send_pix(0, 0, 9'($urandom), 1);
    wait_done(saw);
    tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL t5_after writes=%0d got=%h required=%h",
               got_q.size(), got_q[0], exp_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    got_q.delete();
    exp_q.delete();
    send_cmd(5, 6, 24'($urandom));
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_pix(i, i, 9'($urandom), 0);
    tick();
    checks++;
    if (fb_valid !== 1'b1) begin
      failures++;
      $display("FAIL t6_pre got=%b required=1", fb_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({fb_valid, cmd_ready, in_ready, done} !== 4'b0100) begin
      failures++;
      $display("FAIL t6_post got=%b required=0100",
               {fb_valid, cmd_ready, in_ready, done});
    end
    d0 = done_cnt;
    got_q.delete();
    exp_q.delete();
    fb_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (got_q.size() != 0 || done_cnt != d0) begin
      failures++;
      $display("FAIL t6_quiet writes=%0d dones=%0d required=0 0",
               got_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_random();
    int npix;
    bit saw;
    got_q.delete();
    exp_q.delete();
    rnd_fb = 1;
    for (int b = 0; b < 12; b++) begin
      send_cmd($urandom_range(0, 11), $urandom_range(0, 21),
               24'($urandom));
      npix = $urandom_range(1, 25);
      for (int i = 0; i < npix; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_pix($urandom_range(0, 21), $urandom_range(0, 21),
                 9'($urandom), i == npix - 1);
      end
      wait_done(saw);
      checks++;
      if (!saw || err_oob !== m_err) begin
        failures++;
        $display("FAIL rnd_blk[%0d] done=%b err=%b required=1 %b",
                 b, saw, err_oob, m_err);
      end
      tick();
    end
    rnd_fb = 0;
    fb_ready = 1'b1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rnd_count got=%0d required=%0d",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rnd_pix[%0d] got=%h required=%h",
                 i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_col = '0;
    cmd_row = '0;
    cmd_rgb = '0;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    in_color = '0;
    in_last = 1'b0;
    fb_ready = 1'b1;
    m_col = 0;
    m_row = 0;
    m_rgb = '0;
    m_err = 0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_sweep();
    test_oob();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
